// File: rtl/down_counter_timer.sv
// Loadable WIDTH-bit down-counter/timer with a one-cycle underflow pulse and a sticky done flag.
// Define DOWN_COUNTER_RELOAD_EN for periodic auto-reload; the default build is one-shot.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             underflow,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      busy       <= 1'b0;
      zero       <= 1'b1;
      underflow  <= 1'b0;
      done       <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (load) begin
        count      <= load_value;
        reload_reg <= load_value;
        done       <= 1'b0;
        if (load_value != '0) begin
          state <= RUN;
          busy  <= 1'b1;
          zero  <= 1'b0;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          zero  <= 1'b1;
        end
      end else if (enable && state == RUN) begin
        // RUN always holds count>=1, so the decrement can never wrap.
        if (count > ONE) begin
          count <= count - ONE;
          zero  <= 1'b0;
        end else begin
          underflow <= 1'b1;
          done      <= 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
          count     <= reload_reg;
          zero      <= 1'b0;
`else
          count     <= '0;
          zero      <= 1'b1;
          state     <= EXPIRED;
          busy      <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
